add_accumulator_32bit: RTL and testbench



---
 rtl/add_accumulator_32bit_if.sv | 25 ++
 rtl/add_accumulator_32bit.sv | 107 ++++++++++
 tb/tb_add_accumulator_32bit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/add_accumulator_32bit_if.sv
// Operand/result bus for add_accumulator_32bit: start/len command, valid/ready
// operand stream, and the registered accumulation result.
interface add_accumulator_32bit_if #(
  parameter int unsigned LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [31:0]      acc;
  logic             carry;

  modport master (
    output start, len, in_valid, in_data,
    input  in_ready, busy, done, acc, carry
  );

  modport slave (
    input  start, len, in_valid, in_data,
    output in_ready, busy, done, acc, carry
  );
endinterface

// File: rtl/add_accumulator_32bit.sv
// Counted-stream accumulator wrapped around one full_adder_32bit (c_in = 0).
// Optional ACC_SATURATE_EN pins acc at all-ones from the first carry-out onward.
module full_adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'd0, c_in};
endmodule

module add_accumulator_32bit #(
  parameter int unsigned LEN_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  add_accumulator_32bit_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic [31:0]      acc;
  logic             carry;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [31:0]      sum;
  logic             c_out;

  full_adder_32bit adder (
    .a     (acc),
    .b     (bus.in_data),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      carry     <= 1'b0;
      remaining <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc       <= '0;
            carry     <= 1'b0;
            remaining <= bus.len;
            busy      <= 1'b1;
            if (bus.len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (bus.in_valid && in_ready) begin
`ifdef ACC_SATURATE_EN
            // carry is sticky, so it also marks that saturation already happened
            acc <= (carry || c_out) ? '1 : sum;
`else
            acc <= sum;
`endif
            carry     <= carry | c_out;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) begin
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.acc      = acc;
  assign bus.carry    = carry;
endmodule

// File: tb/tb_add_accumulator_32bit.sv
// Scoreboard bench for add_accumulator_32bit: the driver pushes the expected
// result and done cycle per run; a negedge monitor pops on every done pulse.
module tb_add_accumulator_32bit;
  typedef struct {
    logic [31:0] acc;
    logic        carry;
    int unsigned done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned compared = 0;
  int unsigned mismatched = 0;
  exp_t q[$];

  add_accumulator_32bit_if #(.LEN_W(8)) bus ();

  add_accumulator_32bit #(.LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("acc", bus.acc, e.acc);
        check("carry", {31'd0, bus.carry}, {31'd0, e.carry});
        check("done_cycle", cyc, e.done_cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input int unsigned stall);
    for (int unsigned i = 0; i < stall; i++) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic c, input int unsigned dc);
    exp_t e;
    e.acc = a;
    e.carry = c;
    e.done_cyc = dc;
    q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", q.size(), 32'd0);
  endtask

  logic [31:0] exp_wrap;

  initial begin
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
`ifdef ACC_SATURATE_EN
    exp_wrap = 32'hFFFF_FFFF;
`else
    exp_wrap = 32'h3054_FFC3;
`endif
    tick();
    tick();
    rst = 1'b0;
    check("reset_acc", bus.acc, 32'd0);
    check("reset_flags", {28'd0, bus.carry, bus.busy, bus.in_ready, bus.done}, 32'd0);

    // Two operands, no carry
    start_run(8'd2);
    check("in_ready_cycle1", {31'd0, bus.in_ready}, 32'd1);
    check("busy_cycle1", {31'd0, bus.busy}, 32'd1);
    beat(32'h4C9F_60A3, 0);
    check("acc_after_beat1", bus.acc, 32'h4C9F_60A3);
    beat(32'h05C1_780C, 0);
    push(32'h5260_D8AF, 1'b0, cyc);
    wait_drain();

    // Carry-out / wrap, followed by a back-to-back run
    tick();
    start_run(8'd2);
    beat(32'h60D3_5C7A, 0);
    beat(32'hCF81_A349, 0);
    push(exp_wrap, 1'b1, cyc);
    tick();
    check("hold_acc_idle", bus.acc, exp_wrap);
    check("hold_carry_idle", {31'd0, bus.carry}, 32'd1);
    check("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
    start_run(8'd1);
    check("b2b_acc_cleared", bus.acc, 32'd0);
    check("b2b_carry_cleared", {31'd0, bus.carry}, 32'd0);
    beat(32'h0000_0007, 0);
    push(32'h0000_0007, 1'b0, cyc);
    wait_drain();

    // Stalled stream
    tick();
    start_run(8'd3);
    beat(32'd1, 0);
    beat(32'd2, 2);
    beat(32'd3, 2);
    push(32'd6, 1'b0, cyc);
    wait_drain();

    // Zero length; start held into DONE must be dropped
    tick();
    bus.start = 1'b1;
    bus.len   = 8'd0;
    tick();
    push(32'd0, 1'b0, cyc);
    tick();
    bus.start = 1'b0;
    check("zero_len_back_idle", {31'd0, bus.busy}, 32'd0);
    tick();
    check("start_in_done_dropped", {31'd0, bus.busy}, 32'd0);
    wait_drain();

    // Start pulsed during ACCUM is ignored
    start_run(8'd4);
    beat(32'h1000_0000, 0);
    bus.start = 1'b1;
    bus.len   = 8'd1;
    beat(32'h2000_0000, 0);
    bus.start = 1'b0;
    check("ignored_start_busy", {31'd0, bus.busy}, 32'd1);
    beat(32'h3000_0000, 0);
    beat(32'h4000_0000, 0);
    push(32'hA000_0000, 1'b0, cyc);
    wait_drain();

    // Reset mid-ACCUM with in_valid high
    tick();
    start_run(8'd4);
    beat(32'h1234_5678, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFF_FFFF;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("midrun_reset_acc", bus.acc, 32'd0);
    check("midrun_reset_flags", {28'd0, bus.carry, bus.busy, bus.in_ready, bus.done}, 32'd0);
    tick();
    tick();
    check("no_stray_done", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
